muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//   Multi-cycle multiply/divide engine and HI/LO register file for the MIPS datapath.
//   Replaces the single-cycle product/quotient path with an iterative unit.
//   Operands arrive from the register-file read ports; results are held in HI/LO for mfhi/mflo.
//   busy feeds the hazard unit to stall any later mult/div/mfhi/mflo/mthi/mtlo.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      launch operation; sampled only in IDLE
//   op         in   2      00 multu, 01 mult, 10 divu, 11 div
//   X          in   WIDTH  multiplicand / dividend (rs)
//   Y          in   WIDTH  multiplier / divisor (rt)
//   hi_we      in   1      mthi: HI <= wdata (IDLE only)
//   lo_we      in   1      mtlo: LO <= wdata (IDLE only)
//   wdata      in   WIDTH  data for mthi/mtlo
//   busy       out  1      1 from the cycle after start is accepted until done
//   done       out  1      one-cycle pulse; HI/LO hold the new result in that cycle
//   div_zero   out  1      set with done when divisor was 0; cleared on next start
//   hi         out  WIDTH  HI register
//   lo         out  WIDTH  LO register
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter=0.
//   States: IDLE -> (start) LOAD -> RUN x WIDTH -> FIX -> IDLE.
//   - LOAD (1 cycle): latch |X|,|Y| for signed ops (raw X,Y for unsigned); record result signs.
//   - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle; counter WIDTH-1..0.
//   - FIX (1 cycle): apply signs, write HI/LO, pulse done, deassert busy at the same edge.
//   Latency: start sampled at edge E0; HI/LO and done valid after edge E0+WIDTH+2 (34 for WIDTH=32).
//   Mult: {HI,LO} = full 2*WIDTH-bit product. Signed: negate the product iff sign(X)!=sign(Y).
//   Div: LO = quotient, HI = remainder. Signed quotient truncates toward zero.
//     Remainder takes the sign of the dividend.
//   Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0 (natural result; no flag).
//   Divide by zero (Y==0, div or divu): full latency is kept.
//     Results: LO=all-ones, HI=X unmodified; div_zero=1.
//   start while busy: ignored; the in-flight operation is unaffected.
//   hi_we/lo_we while busy: ignored. start and hi_we/lo_we in the same IDLE cycle: start wins.
//     The write is dropped.
//   hi_we and lo_we together in IDLE: both registers are written with wdata.
//   HI/LO are unchanged from start until the FIX edge; old values stay readable while busy.
//   X, Y, and op are sampled only at the start edge; later changes have no effect.
// TESTING
//   1. multu X=0xFFFFFFFF Y=0xFFFFFFFF -> done at E0+34.
//      Expect HI=0xFFFFFFFE, LO=0x00000001, busy high cycles 1..33.
//   2. mult X=-3 (0xFFFFFFFD) Y=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
//   3. div X=-7 Y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      divu X=100 Y=7 -> LO=14, HI=2.
//      div 0x80000000 / -1 -> LO=0x80000000, HI=0.
//   4. divu X=0x1234 Y=0 -> LO=0xFFFFFFFF, HI=0x1234, div_zero=1 with done; next start clears div_zero.
//   5. Launch mult.
//      Pulse start, op=div, and hi_we (wdata=0xDEAD) at cycle 10.
//      Expect the result to equal the original mult and HI to be unaffected by the write.
//      mthi 0xDEAD in IDLE -> hi=0xDEAD next cycle.
//   6. Assert rst at cycle 15 of a div -> hi=lo=0, busy=0 immediately.
//      No done pulse; a fresh start after release completes normally.

Source files
------------

// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide engine with the HI/LO register pair for mfhi/mflo/mthi/mtlo.
// One shift-add or restoring-subtract step per cycle on magnitudes; signs are applied in FIX.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   x_r, y_r, opnd_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic               sx_r, sy_r;

  logic               is_signed_s, is_div_s;
  logic [WIDTH-1:0]   x_abs_s, y_abs_s;
  logic [WIDTH:0]     mult_sum_s;
  logic [2*WIDTH-1:0] mult_next_s;
  logic [WIDTH:0]     div_shift_s, div_diff_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;
  logic               dz_s;

  assign is_signed_s = op_r[0];
  assign is_div_s    = op_r[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: state_nxt_s = S_RUN;
      S_RUN: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand magnitudes for signed ops
  always_comb begin
    x_abs_s = x_r;
    y_abs_s = y_r;
    if (is_signed_s && x_r[WIDTH-1]) begin
      x_abs_s = -x_r;
    end else begin
      x_abs_s = x_r;
    end
    if (is_signed_s && y_r[WIDTH-1]) begin
      y_abs_s = -y_r;
    end else begin
      y_abs_s = y_r;
    end
  end

  // Iteration step: acc holds {partial, multiplier} for mult, {remainder, quotient} for div
  always_comb begin
    mult_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mult_next_s = {mult_sum_s, acc_r[WIDTH-1:1]};
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    // remainder < divisor keeps the trial difference within WIDTH+1 bits, so its MSB is the borrow
    div_ge_s    = ~div_diff_s[WIDTH];
    if (div_ge_s) begin
      div_rem_s = div_diff_s[WIDTH-1:0];
    end else begin
      div_rem_s = div_shift_s[WIDTH-1:0];
    end
    div_next_s  = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
  end

  // Sign fix-up and divide-by-zero override of the final result
  always_comb begin
    dz_s     = (y_r == {WIDTH{1'b0}});
    prod_s   = acc_r;
    quot_s   = acc_r[WIDTH-1:0];
    rem_s    = acc_r[2*WIDTH-1:WIDTH];
    res_hi_s = {WIDTH{1'b0}};
    res_lo_s = {WIDTH{1'b0}};
    if (is_signed_s && (sx_r ^ sy_r)) begin
      prod_s = -acc_r;
      quot_s = -acc_r[WIDTH-1:0];
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[WIDTH-1:0];
    end
    if (is_signed_s && sx_r) begin
      rem_s = -acc_r[2*WIDTH-1:WIDTH];
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
    if (!is_div_s) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (dz_s) begin
      res_hi_s = x_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = rem_s;
      res_lo_s = quot_s;
    end
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 2'b00;
      x_r      <= {WIDTH{1'b0}};
      y_r      <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      sx_r     <= 1'b0;
      sy_r     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // a start in the same cycle as mthi/mtlo takes priority and drops the write
          if (start) begin
            x_r      <= X;
            y_r      <= Y;
            op_r     <= op;
            busy     <= 1'b1;
            div_zero <= 1'b0;
          end else begin
            if (hi_we) begin
              hi <= wdata;
            end
            if (lo_we) begin
              lo <= wdata;
            end
          end
        end
        S_LOAD: begin
          sx_r   <= x_r[WIDTH-1];
          sy_r   <= y_r[WIDTH-1];
          opnd_r <= is_div_s ? y_abs_s : x_abs_s;
          acc_r  <= {{WIDTH{1'b0}}, (is_div_s ? x_abs_s : y_abs_s)};
          cnt_r  <= CW'(WIDTH - 1);
        end
        S_RUN: begin
          acc_r <= is_div_s ? div_next_s : mult_next_s;
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_FIX: begin
          hi       <= res_hi_s;
          lo       <= res_lo_s;
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= is_div_s & dz_s;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit: latency, signed/unsigned results,
// divide-by-zero, start/write priority while busy, and asynchronous reset mid-operation.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] X, Y, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .X(X), .Y(Y),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; returns 1ns after the accepting edge E0 with operands scrambled
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; X = x; Y = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; X = $urandom; Y = $urandom;
  endtask

  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int lat;
    bit bok;
    launch(o, x, y);
    chk({tag, "_busy_e0"}, busy, 1'b1);
    wait_done(lat, bok);
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_busy_held"}, bok, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int lat;
    bit bok;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; X = 32'd0; Y = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dz", div_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_check("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 1'b0);

    run_check("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_check("mult_minsq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_check("div_neg_dividend", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_check("div_neg_divisor", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_check("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_check("div_overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_check("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    chk("divu_zero_flag", div_zero, 1'b1);

    // start with mthi in the same IDLE cycle: start wins, write dropped, div_zero cleared
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; X = 32'd2; Y = 32'd3; hi_we = 1'b1; wdata = 32'hBEEF;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("dz_cleared_on_start", div_zero, 1'b0);
    chk("start_wins_hi_old", hi, 32'h1234);
    wait_done(lat, bok);
    chk("start_wins_lat", lat, 34);
    chk("start_wins_hi", hi, 32'h0);
    chk("start_wins_lo", lo, 32'd6);

    // start + mthi while busy are both ignored
    launch(OP_MULT, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIV; X = 32'd100; Y = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("busy_hi_readable", hi, 32'h0);
    chk("busy_lo_readable", lo, 32'd6);
    wait_done(lat, bok);
    chk("busy_ignore_lat", lat, 24);
    chk("busy_ignore_hi", hi, 32'h0);
    chk("busy_ignore_lo", lo, 32'd42);
    @(posedge clk);
    #1;
    chk("busy_ignore_no_relaunch", busy, 1'b0);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hDEAD);
    chk("mthi_lo_kept", lo, 32'd42);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo_hi", hi, 32'hCAFE);
    chk("mthi_mtlo_lo", lo, 32'hCAFE);

    // asynchronous reset in the middle of a divide
    launch(OP_DIV, 32'd1000, 32'd9);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(lat, bok);
    chk("midrst_no_done", done, 1'b0);
    run_check("after_rst", OP_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
